// File: rtl/encode_164.sv
// Sequential 16-to-4 encoder: accepts a multi-hot vector, then emits one index per set bit.
// Optional build macro ENCODE_164_MSB_FIRST_EN selects highest-bit-first emission order.
module encode_164 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        zero_err,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]  state, state_n;
    logic [15:0] pending, pending_n;
    logic [3:0]  idx_n;
    logic        last_n;
    logic        zero_n;
    logic        accept;
    logic        emit;

    // Position of the set bit that is emitted next from v.
    function automatic logic [3:0] pick(input logic [15:0] v);
        logic [3:0] r;
        r = 4'h0;
`ifdef ENCODE_164_MSB_FIRST_EN
        for (int i = 0; i < 16; i++)
            if (v[i]) r = i[3:0];
`else
        for (int i = 15; i >= 0; i--)
            if (v[i]) r = i[3:0];
`endif
        return r;
    endfunction

    function automatic logic single(input logic [15:0] v);
        return (v != 16'h0000) && ((v & (v - 16'd1)) == 16'h0000);
    endfunction

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign emit     = out_valid && out_ready;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_n   = state;
        pending_n = pending;
        idx_n     = out_idx;
        last_n    = out_last;
        zero_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (in_vec == 16'h0000) begin
                        zero_n = 1'b1;
                    end else begin
                        pending_n = in_vec;
                        state_n   = ST_SCAN;
                        idx_n     = pick(in_vec);
                        last_n    = single(in_vec);
                    end
                end
            end
            ST_SCAN: begin
                if (emit) begin
                    pending_n = pending & ~(16'h0001 << out_idx);
                    if (pending_n == 16'h0000) begin
                        state_n = ST_IDLE;
                        idx_n   = 4'h0;
                        last_n  = 1'b0;
                    end else begin
                        idx_n  = pick(pending_n);
                        last_n = single(pending_n);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pending   <= 16'h0000;
            out_idx   <= 4'h0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            zero_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            out_idx   <= idx_n;
            out_last  <= last_n;
            out_valid <= (state_n == ST_SCAN);
            zero_err  <= zero_n;
            busy      <= (state_n == ST_SCAN);
        end
    end

endmodule

// File: tb/tb_encode_164.sv
// Self-checking bench for encode_164: expected index streams come from a bit-walk model.
module tb_encode_164;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_vec = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        zero_err;
    logic        busy;

    int tests = 0;
    int fails = 0;

    encode_164 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last), .zero_err(zero_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: list the set-bit positions in emission order.
    function automatic void model(input logic [15:0] v, output int q[$]);
        q = {};
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
`ifdef ENCODE_164_MSB_FIRST_EN
                q.push_front(i);
`else
                q.push_back(i);
`endif
            end
        end
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        cmp({name, " out_valid"}, int'(out_valid), 0);
        cmp({name, " out_idx"},   int'(out_idx),   0);
        cmp({name, " out_last"},  int'(out_last),  0);
        cmp({name, " zero_err"},  int'(zero_err),  0);
        cmp({name, " busy"},      int'(busy),      0);
        cmp({name, " in_ready"},  int'(in_ready),  1);
    endtask

    // Present one vector for a single cycle; inputs change on negedge.
    task automatic accept(input logic [15:0] v);
        @(negedge clk);
        cmp("accept in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_vec   = v;
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = 16'h0000;
    endtask

    // Drain the index stream for v. mode: 0 ready always, 1 random, 2 stall first 3 cycles.
    task automatic collect(input string name, input logic [15:0] v, input int mode, input bit toggle);
        int q[$];
        int cycles;
        int k;
        model(v, q);
        k = q.size();
        cycles = 0;
        // First check happens at the negedge right after the accept edge.
        while (q.size() > 0) begin
            if (cycles > 200) begin
                cmp({name, " timeout"}, q.size(), 0);
                break;
            end
            if (out_valid !== 1'b1) begin
                cmp({name, " out_valid"}, int'(out_valid), 1);
            end else begin
                cmp({name, " out_idx"},  int'(out_idx),  q[0]);
                cmp({name, " out_last"}, int'(out_last), int'(q.size() == 1));
                cmp({name, " in_ready"}, int'(in_ready), 0);
                cmp({name, " busy"},     int'(busy),     1);
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cycles >= 3);
            endcase
            if (toggle) begin
                in_valid = 1'($urandom_range(0, 1));
                in_vec   = 16'($urandom);
            end
            if (out_valid === 1'b1 && out_ready) void'(q.pop_front());
            @(negedge clk);
            cycles++;
        end
        in_valid  = 1'b0;
        in_vec    = 16'h0000;
        out_ready = 1'b0;
        if (mode == 0) cmp({name, " scan cycles"}, cycles, k);
        cmp({name, " done out_valid"}, int'(out_valid), 0);
        cmp({name, " done in_ready"},  int'(in_ready),  1);
    endtask

    // Accept task ends at the negedge after the accept edge; collect starts there.
    task automatic run_vec(input string name, input logic [15:0] v, input int mode, input bit toggle);
        accept(v);
        collect(name, v, mode, toggle);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        accept(16'h00F0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        cmp("mid-scan busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmp("post-rst out_valid", int'(out_valid), 0);
        end
        cmp("post-rst in_ready", int'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    task automatic test_sparse;
        run_vec("sparse", 16'h8421, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        run_vec("backpr", 16'h0006, 2, 1'b0);
    endtask

    task automatic test_zero;
        accept(16'h0000);
        cmp("zero zero_err",  int'(zero_err),  1);
        cmp("zero out_valid", int'(out_valid), 0);
        cmp("zero in_ready",  int'(in_ready),  1);
        @(negedge clk);
        cmp("zero pulse end", int'(zero_err),  0);
        cmp("zero idle",      int'(out_valid), 0);
    endtask

    task automatic test_full_ignored;
        run_vec("full", 16'hFFFF, 0, 1'b1);
    endtask

    task automatic test_single;
        for (int b = 0; b < 16; b += 5) run_vec("single", 16'h0001 << b, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        accept(16'h0003);
        collect("b2b a", 16'h0003, 0, 1'b0);
        in_valid = 1'b1;
        in_vec   = 16'h0300;
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = 16'h0000;
        collect("b2b b", 16'h0300, 0, 1'b0);
    endtask

    task automatic test_random;
        logic [15:0] v;
        for (int n = 0; n < 40; n++) begin
            v = 16'($urandom);
            if (n % 8 == 0) v = 16'h0000;
            if (v == 16'h0000) begin
                test_zero();
            end else begin
                run_vec("random", v, 1, 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_backpressure();
        test_zero();
        test_full_ignored();
        test_single();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
